shift_arbiter: RTL and testbench
================================

SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 Parameter WIDTH, default 64, data width of operands and result.
REQ-002 Parameter SHW, default 6, shift-amount width; equals log2(WIDTH).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  2  per-requester request valid; bit i belongs to requester i.
REQ-006 req_ready  output  2  per-requester grant/accept; bit i high = request i accepted this cycle.
REQ-007 req_data0, req_data1  input  WIDTH each  operand per requester.
REQ-008 req_shamt0, req_shamt1  input  SHW each  shift amount per requester.
REQ-009 sh_in  output  WIDTH  operand driven to the shared shifter.
REQ-010 sh_amount  output  SHW  shift amount driven to the shared shifter.
REQ-011 sh_result  input  WIDTH  combinational result returned by the shared shifter.
REQ-012 rsp_valid  output  1  response valid.
REQ-013 rsp_ready  input  1  response consumer ready.
REQ-014 rsp_data  output  WIDTH  registered shift result.
REQ-015 rsp_id  output  1  index of requester that owns rsp_data.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 FSM SHALL have three states: IDLE, SHIFT, RESP.
REQ-018 IDLE: if any req_valid bit is set, assert exactly one req_ready bit in that same cycle (combinational from req_valid and priority pointer), latch the granted operand, shamt and id into operand registers, and go to SHIFT; otherwise stay in IDLE.
REQ-019 req_ready SHALL be all-zero in SHIFT and RESP, and in IDLE when no request is valid.
REQ-020 Arbitration round-robin: pointer prio=0 favours requester 0, prio=1 favours requester 1; lone valid requester always wins regardless of prio.
REQ-021 On each grant, prio SHALL become the complement of the granted id.
REQ-022 sh_in and sh_amount SHALL be driven from the operand registers at all times, never combinationally from req_* ports.
REQ-023 SHIFT: capture sh_result into rsp_data register, go to RESP; lasts exactly one cycle.
REQ-024 RESP: rsp_valid=1; rsp_data and rsp_id SHALL hold stable until rsp_ready=1 is sampled; then go to IDLE.
REQ-025 A new request SHALL NOT be accepted in the cycle the RESP handshake completes; earliest next grant is the following cycle (IDLE).
REQ-026 Accept-to-rsp_valid latency: 2 cycles (grant edge -> SHIFT, SHIFT edge -> RESP); minimum throughput one result per 3 cycles.
REQ-027 Shift amount passed unmodified; any value 0..WIDTH-1 is legal; shamt=0 returns operand unchanged.
REQ-028 Requester dropping req_valid while not granted SHALL lose no state; requester bits are level-sampled only in IDLE.
REQ-029 rsp_valid SHALL be asserted only in RESP; busy = (state != IDLE).

Reset
REQ-030 rst_n low SHALL immediately force state=IDLE, prio=0, rsp_valid=0, req_ready=0, busy=0, rsp_id=0, rsp_data=0, operand registers=0.
REQ-031 Reset asserted mid-SHIFT or mid-RESP SHALL abandon the transaction with no response issued.
REQ-032 After rst_n deasserts, first grant can occur in the first rising edge where req_valid is nonzero.

Verification
REQ-033 Single request: req_valid=01, data0=0x8000_0000_0000_0000, shamt0=4 -> req_ready=01 in that cycle, rsp_valid two cycles later, rsp_data = shifter output for that operand and amount, rsp_id=0.
REQ-034 Contention: req_valid=11 held for four transactions from reset, rsp_ready=1 -> grants alternate 0,1,0,1; rsp_id sequence 0,1,0,1; one response per 3 cycles.
REQ-035 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_data, rsp_id stable, req_ready=00 throughout; req_valid=10 pending is granted only in the cycle after rsp_ready=1 completes the handshake.
REQ-036 Boundaries: shamt=0 -> rsp_data = operand; shamt=63 with data=0xFFFF_FFFF_FFFF_FFFF -> rsp_data equals shifter result for amount 63.
REQ-037 Reset mid-RESP: rst_n low while rsp_valid=1 -> rsp_valid=0, busy=0 immediately (asynchronously); after release with req_valid=11, first grant goes to requester 0.

Source files
------------

// File: rtl/shift_arbiter.sv
// Two-requester round-robin front end for one shared combinational shifter.
// Sequence: grant and latch in IDLE, capture the shifter result in SHIFT, hold the response in RESP.
module shift_arbiter #(
   parameter int WIDTH = 64,
   parameter int SHW   = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [WIDTH-1:0] req_data0,
   input  logic [WIDTH-1:0] req_data1,
   input  logic [SHW-1:0]   req_shamt0,
   input  logic [SHW-1:0]   req_shamt1,
   output logic [WIDTH-1:0] sh_in,
   output logic [SHW-1:0]   sh_amount,
   input  logic [WIDTH-1:0] sh_result,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_id,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic             r_prio;
   logic [WIDTH-1:0] r_op_data;
   logic [SHW-1:0]   r_op_shamt;
   logic             r_op_id;
   logic [WIDTH-1:0] r_rsp_data;
   logic             w_grant;
   logic             w_gnt_id;

   // rst_n gates the grant so req_ready is low for the whole time reset is held
   always_comb begin
      w_gnt_id  = 1'b0;
      w_grant   = 1'b0;
      w_next    = r_state;
      req_ready = 2'b00;
      case (req_valid)
         2'b01:   w_gnt_id = 1'b0;
         2'b10:   w_gnt_id = 1'b1;
         2'b11:   w_gnt_id = r_prio;
         default: w_gnt_id = 1'b0;
      endcase
      case (r_state)
         IDLE: begin
            if (rst_n && (req_valid != 2'b00)) begin
               w_grant   = 1'b1;
               w_next    = SHIFT;
               req_ready = w_gnt_id ? 2'b10 : 2'b01;
            end
         end
         SHIFT: w_next = RESP;
         RESP: begin
            if (rsp_ready) begin
               w_next = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prio     <= 1'b0;
         r_op_data  <= '0;
         r_op_shamt <= '0;
         r_op_id    <= 1'b0;
         r_rsp_data <= '0;
      end else begin
         if (w_grant) begin
            r_op_data  <= w_gnt_id ? req_data1 : req_data0;
            r_op_shamt <= w_gnt_id ? req_shamt1 : req_shamt0;
            r_op_id    <= w_gnt_id;
            r_prio     <= ~w_gnt_id;
         end
         if (r_state == SHIFT) begin
            r_rsp_data <= sh_result;
         end
      end
   end

   assign sh_in     = r_op_data;
   assign sh_amount = r_op_shamt;
   assign rsp_valid = (r_state == RESP);
   assign rsp_data  = r_rsp_data;
   assign rsp_id    = r_op_id;
   assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: directed scenarios plus a randomized run scored against a transaction-level model.
// The shared shifter is modelled here as a logical right shift.
module tb_shift_arbiter;

   logic        clk;
   logic        rst_n;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [63:0] req_data0;
   logic [63:0] req_data1;
   logic [5:0]  req_shamt0;
   logic [5:0]  req_shamt1;
   logic [63:0] sh_in;
   logic [5:0]  sh_amount;
   logic [63:0] sh_result;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [63:0] rsp_data;
   logic        rsp_id;
   logic        busy;

   int   checks = 0;
   int   errors = 0;
   logic m_prio;

   shift_arbiter #(.WIDTH(64), .SHW(6)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_data0  (req_data0),
      .req_data1  (req_data1),
      .req_shamt0 (req_shamt0),
      .req_shamt1 (req_shamt1),
      .sh_in      (sh_in),
      .sh_amount  (sh_amount),
      .sh_result  (sh_result),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .rsp_id     (rsp_id),
      .busy       (busy)
   );

   assign sh_result = sh_in >> sh_amount;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst_n     = 1'b0;
      req_valid = 2'b00;
      rsp_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst_n  = 1'b1;
      m_prio = 1'b0;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      req_valid = 2'b11;
      req_data0 = rnd64();
      req_data1 = rnd64();
      repeat (2) @(negedge clk);
      #1;
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL reset_rsp_id: got %b expected 0", rsp_id); end
      checks++; if (rsp_data !== 64'd0) begin errors++; $display("FAIL reset_rsp_data: got %h expected 0", rsp_data); end
      checks++; if (sh_in !== 64'd0 || sh_amount !== 6'd0) begin errors++; $display("FAIL reset_operand: got %h/%0d expected 0/0", sh_in, sh_amount); end
      @(negedge clk);
      req_valid = 2'b00;
      rst_n     = 1'b1;
      m_prio    = 1'b0;
   endtask

   task automatic test_single();
      @(negedge clk);
      req_valid  = 2'b01;
      req_data0  = 64'h8000_0000_0000_0000;
      req_shamt0 = 6'd4;
      req_data1  = rnd64();
      req_shamt1 = 6'($urandom_range(0, 63));
      rsp_ready  = 1'b1;
      #1;
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_grant: got %b expected 01", req_ready); end
      @(negedge clk);
      req_valid = 2'b00;
      req_data0 = rnd64();
      #1;
      checks++; if (rsp_valid !== 1'b0 || busy !== 1'b1 || req_ready !== 2'b00) begin errors++; $display("FAIL single_shift_ctl: got v=%b busy=%b rdy=%b expected 0/1/00", rsp_valid, busy, req_ready); end
      checks++; if (sh_in !== 64'h8000_0000_0000_0000 || sh_amount !== 6'd4) begin errors++; $display("FAIL single_operand: got %h/%0d expected 8000000000000000/4", sh_in, sh_amount); end
      @(negedge clk);
      #1;
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid: got %b expected 1", rsp_valid); end
      checks++; if (rsp_data !== 64'h0800_0000_0000_0000 || rsp_id !== 1'b0) begin errors++; $display("FAIL single_rsp: got %h id %b expected 0800000000000000 id 0", rsp_data, rsp_id); end
      @(negedge clk);
      #1;
      checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL single_done: got busy=%b v=%b expected 0/0", busy, rsp_valid); end
      m_prio = 1'b1;
   endtask

   task automatic test_contention();
      logic [63:0] exp_data;
      logic        exp_id;
      logic [1:0]  exp_rdy;
      do_reset();
      rsp_ready = 1'b1;
      exp_data  = '0;
      exp_id    = 1'b0;
      for (int cyc = 0; cyc < 12; cyc++) begin
         @(negedge clk);
         req_valid  = 2'b11;
         req_data0  = rnd64();
         req_data1  = rnd64();
         req_shamt0 = 6'($urandom_range(0, 63));
         req_shamt1 = 6'($urandom_range(0, 63));
         #1;
         exp_rdy = 2'b00;
         if (cyc % 3 == 0) begin
            exp_id   = ((cyc / 3) % 2) == 1;
            exp_rdy  = exp_id ? 2'b10 : 2'b01;
            exp_data = exp_id ? (req_data1 >> req_shamt1) : (req_data0 >> req_shamt0);
         end
         checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL contention_grant c%0d: got %b expected %b", cyc, req_ready, exp_rdy); end
         checks++; if (rsp_valid !== (cyc % 3 == 2)) begin errors++; $display("FAIL contention_valid c%0d: got %b expected %b", cyc, rsp_valid, (cyc % 3 == 2)); end
         if (cyc % 3 == 2) begin
            checks++; if (rsp_id !== exp_id || rsp_data !== exp_data) begin errors++; $display("FAIL contention_rsp c%0d: got %h id %b expected %h id %b", cyc, rsp_data, rsp_id, exp_data, exp_id); end
         end
      end
      @(negedge clk);
      req_valid = 2'b00;
      m_prio    = 1'b0;
   endtask

   task automatic test_backpressure();
      logic [63:0] exp0;
      logic [63:0] exp1;
      @(negedge clk);
      req_valid  = 2'b01;
      req_data0  = rnd64();
      req_shamt0 = 6'($urandom_range(0, 63));
      exp0       = req_data0 >> req_shamt0;
      rsp_ready  = 1'b0;
      #1;
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL bp_grant0: got %b expected 01", req_ready); end
      @(negedge clk);
      req_valid  = 2'b10;
      req_data1  = rnd64();
      req_shamt1 = 6'($urandom_range(0, 63));
      exp1       = req_data1 >> req_shamt1;
      #1;
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_shift_ready: got %b expected 00", req_ready); end
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         #1;
         checks++; if (rsp_valid !== 1'b1 || req_ready !== 2'b00) begin errors++; $display("FAIL bp_stall%0d_ctl: got v=%b rdy=%b expected 1/00", k, rsp_valid, req_ready); end
         checks++; if (rsp_data !== exp0 || rsp_id !== 1'b0) begin errors++; $display("FAIL bp_stall%0d_data: got %h id %b expected %h id 0", k, rsp_data, rsp_id, exp0); end
      end
      @(negedge clk);
      rsp_ready = 1'b1;
      #1;
      checks++; if (rsp_valid !== 1'b1 || req_ready !== 2'b00) begin errors++; $display("FAIL bp_handshake: got v=%b rdy=%b expected 1/00", rsp_valid, req_ready); end
      @(negedge clk);
      #1;
      checks++; if (req_ready !== 2'b10 || busy !== 1'b0) begin errors++; $display("FAIL bp_next_grant: got rdy=%b busy=%b expected 10/0", req_ready, busy); end
      @(negedge clk);
      req_valid = 2'b00;
      @(negedge clk);
      #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_data !== exp1 || rsp_id !== 1'b1) begin errors++; $display("FAIL bp_second_rsp: got v=%b %h id %b expected 1 %h id 1", rsp_valid, rsp_data, rsp_id, exp1); end
      @(negedge clk);
      m_prio = 1'b0;
   endtask

   task automatic test_boundaries();
      logic [63:0] d   [2];
      logic [5:0]  s   [2];
      logic [63:0] exp [2];
      d[0] = rnd64();               s[0] = 6'd0;  exp[0] = d[0];
      d[1] = 64'hFFFF_FFFF_FFFF_FFFF; s[1] = 6'd63; exp[1] = 64'd1;
      rsp_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         req_valid  = (i == 0) ? 2'b10 : 2'b01;
         req_data0  = (i == 0) ? rnd64() : d[i];
         req_shamt0 = (i == 0) ? 6'd17 : s[i];
         req_data1  = (i == 0) ? d[i] : rnd64();
         req_shamt1 = (i == 0) ? s[i] : 6'd9;
         #1;
         checks++; if (req_ready !== req_valid) begin errors++; $display("FAIL bound%0d_grant: got %b expected %b", i, req_ready, req_valid); end
         @(negedge clk);
         req_valid = 2'b00;
         @(negedge clk);
         #1;
         checks++; if (rsp_valid !== 1'b1 || rsp_data !== exp[i] || rsp_id !== (i == 0)) begin errors++; $display("FAIL bound%0d_rsp: got v=%b %h id %b expected 1 %h id %b", i, rsp_valid, rsp_data, rsp_id, exp[i], (i == 0)); end
         @(negedge clk);
      end
      m_prio = 1'b1;
   endtask

   task automatic test_reset_mid();
      // Leave prio pointing at requester 1 so the post-reset grant proves prio was cleared.
      @(negedge clk);
      req_valid  = 2'b01;
      req_data0  = rnd64();
      req_shamt0 = 6'($urandom_range(0, 63));
      rsp_ready  = 1'b0;
      @(negedge clk);
      req_valid = 2'b00;
      @(negedge clk);
      #1;
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL midresp_pre: got v=%b expected 1", rsp_valid); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midresp_async: got v=%b busy=%b expected 0/0", rsp_valid, busy); end
      checks++; if (rsp_data !== 64'd0 || rsp_id !== 1'b0 || sh_in !== 64'd0) begin errors++; $display("FAIL midresp_regs: got %h id %b in %h expected 0", rsp_data, rsp_id, sh_in); end
      @(negedge clk);
      rst_n     = 1'b1;
      req_valid = 2'b11;
      req_data0 = rnd64();
      req_data1 = rnd64();
      #1;
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL midresp_first_grant: got %b expected 01", req_ready); end
      @(negedge clk);
      req_valid = 2'b00;
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midshift_async: got busy=%b expected 0", busy); end
      @(negedge clk);
      rst_n     = 1'b1;
      rsp_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1;
         checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midshift_abandon%0d: got v=%b busy=%b expected 0/0", k, rsp_valid, busy); end
      end
      m_prio = 1'b0;
   endtask

   task automatic test_random();
      logic        outstanding;
      int          g_cyc;
      logic        exp_id;
      logic [63:0] exp_data;
      logic [1:0]  exp_rdy;
      logic        exp_valid;
      logic        gid;
      do_reset();
      outstanding = 1'b0;
      g_cyc       = 0;
      exp_id      = 1'b0;
      exp_data    = '0;
      for (int cyc = 0; cyc < 300; cyc++) begin
         @(negedge clk);
         req_valid  = 2'($urandom_range(0, 3));
         req_data0  = rnd64();
         req_data1  = rnd64();
         req_shamt0 = 6'($urandom_range(0, 63));
         req_shamt1 = 6'($urandom_range(0, 63));
         rsp_ready  = ($urandom_range(0, 3) != 0);
         #1;
         gid     = (req_valid == 2'b11) ? m_prio : req_valid[1];
         exp_rdy = (outstanding || req_valid == 2'b00) ? 2'b00 : (gid ? 2'b10 : 2'b01);
         exp_valid = outstanding && (cyc >= g_cyc + 2);
         checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rand_ready c%0d: got %b expected %b", cyc, req_ready, exp_rdy); end
         checks++; if (rsp_valid !== exp_valid || busy !== outstanding) begin errors++; $display("FAIL rand_ctl c%0d: got v=%b busy=%b expected %b/%b", cyc, rsp_valid, busy, exp_valid, outstanding); end
         if (exp_valid) begin
            checks++; if (rsp_data !== exp_data || rsp_id !== exp_id) begin errors++; $display("FAIL rand_rsp c%0d: got %h id %b expected %h id %b", cyc, rsp_data, rsp_id, exp_data, exp_id); end
         end
         if (exp_rdy != 2'b00) begin
            outstanding = 1'b1;
            g_cyc       = cyc;
            exp_id      = gid;
            exp_data    = gid ? (req_data1 >> req_shamt1) : (req_data0 >> req_shamt0);
            m_prio      = ~gid;
         end else if (exp_valid && rsp_ready) begin
            outstanding = 1'b0;
         end
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      req_valid  = 2'b00;
      rsp_ready  = 1'b0;
      req_data0  = '0;
      req_data1  = '0;
      req_shamt0 = '0;
      req_shamt1 = '0;
      m_prio     = 1'b0;
      test_reset();
      test_single();
      test_contention();
      test_backpressure();
      test_boundaries();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
